// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants, serializer state encoding and the standard
// zigzag scan table.
package jpeg_pkg;

  localparam int BLOCK_COEFFS = 64;
  localparam int COEFF_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } ser_state_t;

  // Scan position -> natural (row-major) index of an 8x8 block.
  function automatic logic [5:0] zz(input logic [5:0] pos);
    logic [5:0] idx;
    idx = 6'd0;
    case (pos)
      6'd0:  idx = 6'd0;  6'd1:  idx = 6'd1;  6'd2:  idx = 6'd8;  6'd3:  idx = 6'd16;
      6'd4:  idx = 6'd9;  6'd5:  idx = 6'd2;  6'd6:  idx = 6'd3;  6'd7:  idx = 6'd10;
      6'd8:  idx = 6'd17; 6'd9:  idx = 6'd24; 6'd10: idx = 6'd32; 6'd11: idx = 6'd25;
      6'd12: idx = 6'd18; 6'd13: idx = 6'd11; 6'd14: idx = 6'd4;  6'd15: idx = 6'd5;
      6'd16: idx = 6'd12; 6'd17: idx = 6'd19; 6'd18: idx = 6'd26; 6'd19: idx = 6'd33;
      6'd20: idx = 6'd40; 6'd21: idx = 6'd48; 6'd22: idx = 6'd41; 6'd23: idx = 6'd34;
      6'd24: idx = 6'd27; 6'd25: idx = 6'd20; 6'd26: idx = 6'd13; 6'd27: idx = 6'd6;
      6'd28: idx = 6'd7;  6'd29: idx = 6'd14; 6'd30: idx = 6'd21; 6'd31: idx = 6'd28;
      6'd32: idx = 6'd35; 6'd33: idx = 6'd42; 6'd34: idx = 6'd49; 6'd35: idx = 6'd56;
      6'd36: idx = 6'd57; 6'd37: idx = 6'd50; 6'd38: idx = 6'd43; 6'd39: idx = 6'd36;
      6'd40: idx = 6'd29; 6'd41: idx = 6'd22; 6'd42: idx = 6'd15; 6'd43: idx = 6'd23;
      6'd44: idx = 6'd30; 6'd45: idx = 6'd37; 6'd46: idx = 6'd44; 6'd47: idx = 6'd51;
      6'd48: idx = 6'd58; 6'd49: idx = 6'd59; 6'd50: idx = 6'd52; 6'd51: idx = 6'd45;
      6'd52: idx = 6'd38; 6'd53: idx = 6'd31; 6'd54: idx = 6'd39; 6'd55: idx = 6'd46;
      6'd56: idx = 6'd53; 6'd57: idx = 6'd60; 6'd58: idx = 6'd61; 6'd59: idx = 6'd54;
      6'd60: idx = 6'd47; 6'd61: idx = 6'd55; 6'd62: idx = 6'd62; 6'd63: idx = 6'd63;
      default: idx = 6'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/coeff_serializer_if.sv
// Block-in / coefficient-out bus of the coefficient serializer.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge, and never
// withdraws valid before the transfer.
interface coeff_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH*64-1:0] block_in_flat;
  logic                block_in_valid;
  logic                block_in_ready;
  logic [WIDTH-1:0]    coeff_out;
  logic [5:0]          coeff_index;
  logic                coeff_valid;
  logic                coeff_ready;
  logic                block_done;

  // master: block producer plus coefficient consumer around the serializer
  modport master (
    output block_in_flat, block_in_valid, coeff_ready,
    input  block_in_ready, coeff_out, coeff_index, coeff_valid, block_done
  );

  // slave: the serializer itself
  modport slave (
    input  block_in_flat, block_in_valid, coeff_ready,
    output block_in_ready, coeff_out, coeff_index, coeff_valid, block_done
  );
endinterface

// File: rtl/coeff_serializer_zigzag_rom.sv
// Combinational scan position to natural index map, shared with the decoder.
module zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] pos,
  output logic [5:0] idx
);
  assign idx = zz(pos);
endmodule

// File: rtl/coeff_serializer.sv
// Serializes one captured 8x8 coefficient block into 64 indexed beats,
// followed by a single-cycle block_done.
module coeff_serializer
  import jpeg_pkg::*;
#(
  parameter int WIDTH  = COEFF_W,
  parameter int ZIGZAG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  coeff_serializer_if.slave  bus,
  output ser_state_t         dbg_state
);

  ser_state_t       state, state_nxt;
  logic [5:0]       pos;
  logic [5:0]       zz_idx;
  logic [5:0]       scan_idx;
  logic [WIDTH-1:0] coef_buf [BLOCK_COEFFS];
  logic             capture;
  logic             beat;
  logic             last_beat;

  assign capture   = bus.block_in_valid && bus.block_in_ready;
  assign beat      = bus.coeff_valid && bus.coeff_ready;
  assign last_beat = beat && (pos == 6'd63);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (capture) state_nxt = S_SEND;
      S_SEND:  if (last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = capture ? S_SEND : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pure state decode: no combinational path from either valid or ready.
  always_comb begin
    bus.block_in_ready = 1'b0;
    bus.coeff_valid    = 1'b0;
    bus.block_done     = 1'b0;
    case (state)
      S_IDLE: bus.block_in_ready = 1'b1;
      S_SEND: bus.coeff_valid    = 1'b1;
      S_DONE: begin
        bus.block_in_ready = 1'b1;
        bus.block_done     = 1'b1;
      end
      default: bus.block_in_ready = 1'b1;
    endcase
  end

  // pos parks at 63 after the final beat; only a new capture rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 6'd0;
      for (int k = 0; k < BLOCK_COEFFS; k++) coef_buf[k] <= '0;
    end else if (capture) begin
      pos <= 6'd0;
      for (int k = 0; k < BLOCK_COEFFS; k++) coef_buf[k] <= bus.block_in_flat[k*WIDTH +: WIDTH];
    end else if (beat && (pos != 6'd63)) begin
      pos <= pos + 6'd1;
    end
  end

  zigzag_rom u_zigzag_rom (
    .pos (pos),
    .idx (zz_idx)
  );

  assign scan_idx        = (ZIGZAG != 0) ? zz_idx : pos;
  assign bus.coeff_index = scan_idx;
  assign bus.coeff_out   = coef_buf[scan_idx];

endmodule

// File: tb/tb_coeff_serializer.sv
// Directed bench for coeff_serializer: one natural-order and one zigzag instance.
module tb_coeff_serializer;
  import jpeg_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coeff_serializer_if #(.WIDTH(W)) if_n ();
  coeff_serializer_if #(.WIDTH(W)) if_z ();
  ser_state_t st_n, st_z;

  coeff_serializer #(.WIDTH(W), .ZIGZAG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(if_n), .dbg_state(st_n)
  );
  coeff_serializer #(.WIDTH(W), .ZIGZAG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(if_z), .dbg_state(st_z)
  );

  int checks = 0;
  int errors = 0;

  int zz_ref [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [W-1:0] blk [64];
  logic [W-1:0] rx  [64];

  function automatic logic [W*64-1:0] pack_blk();
    logic [W*64-1:0] f;
    for (int k = 0; k < 64; k++) f[k*W +: W] = blk[k];
    return f;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if_n.block_in_flat = '0; if_n.block_in_valid = 1'b0; if_n.coeff_ready = 1'b0;
    if_z.block_in_flat = '0; if_z.block_in_valid = 1'b0; if_z.coeff_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({if_n.block_in_ready, if_n.coeff_valid, if_n.block_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl_nat: got rdy/vld/done=%b want 100",
               {if_n.block_in_ready, if_n.coeff_valid, if_n.block_done});
    end
    checks++;
    if ({if_n.coeff_out, if_n.coeff_index} !== 22'd0) begin
      errors++;
      $display("FAIL reset_data_nat: got out=%h idx=%0d want 0/0", if_n.coeff_out, if_n.coeff_index);
    end
    checks++;
    if ({if_z.block_in_ready, if_z.coeff_valid, if_z.block_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl_zz: got rdy/vld/done=%b want 100",
               {if_z.block_in_ready, if_z.coeff_valid, if_z.block_done});
    end
    checks++;
    if ({if_z.coeff_out, if_z.coeff_index} !== 22'd0) begin
      errors++;
      $display("FAIL reset_data_zz: got out=%h idx=%0d want 0/0", if_z.coeff_out, if_z.coeff_index);
    end
    checks++;
    if (st_n !== S_IDLE || st_z !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d want 0/0", st_n, st_z);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_n.block_in_ready, if_n.coeff_valid, if_n.block_done} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_idle: got rdy/vld/done=%b want 100",
               {if_n.block_in_ready, if_n.coeff_valid, if_n.block_done});
    end
  endtask

  task automatic test_natural();
    for (int k = 0; k < 64; k++) blk[k] = W'(k + 100);
    if_n.block_in_flat = pack_blk();
    if_n.coeff_ready = 1'b1;
    if_n.block_in_valid = 1'b1;
    @(negedge clk);
    if_n.block_in_valid = 1'b0;
    for (int b = 0; b < 64; b++) begin
      checks++;
      if ({if_n.coeff_valid, if_n.block_done, if_n.coeff_index, if_n.coeff_out} !==
          {2'b10, 6'(b), W'(b + 100)}) begin
        errors++;
        $display("FAIL nat_beat %0d: got vld=%b done=%b idx=%0d out=%h want 1/0/%0d/%h", b,
                 if_n.coeff_valid, if_n.block_done, if_n.coeff_index, if_n.coeff_out, b, b + 100);
      end
      @(negedge clk);
    end
    checks++;
    if ({if_n.block_done, if_n.coeff_valid, if_n.block_in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL nat_done: got done/vld/rdy=%b want 101",
               {if_n.block_done, if_n.coeff_valid, if_n.block_in_ready});
    end
    @(negedge clk);
    checks++;
    if (if_n.block_done !== 1'b0 || st_n !== S_IDLE) begin
      errors++;
      $display("FAIL nat_done_pulse: got done=%b state=%0d want 0/0", if_n.block_done, st_n);
    end
  endtask

  task automatic test_zigzag();
    for (int k = 0; k < 64; k++) blk[k] = W'(k);
    if_z.block_in_flat = pack_blk();
    if_z.coeff_ready = 1'b1;
    if_z.block_in_valid = 1'b1;
    @(negedge clk);
    if_z.block_in_valid = 1'b0;
    if_z.block_in_flat = '1;  // must not disturb the captured block
    for (int b = 0; b < 64; b++) begin
      checks++;
      if ({if_z.coeff_valid, if_z.coeff_index, if_z.coeff_out} !==
          {1'b1, 6'(zz_ref[b]), W'(zz_ref[b])}) begin
        errors++;
        $display("FAIL zz_beat %0d: got vld=%b idx=%0d out=%h want 1/%0d/%h", b,
                 if_z.coeff_valid, if_z.coeff_index, if_z.coeff_out, zz_ref[b], zz_ref[b]);
      end
      @(negedge clk);
    end
    checks++;
    if ({if_z.block_done, if_z.coeff_valid} !== 2'b10) begin
      errors++;
      $display("FAIL zz_done: got done/vld=%b want 10", {if_z.block_done, if_z.coeff_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int beat, stall, cyc;
    for (int k = 0; k < 64; k++) blk[k] = W'(16'h1000 + k * 7);
    if_n.block_in_flat = pack_blk();
    if_n.coeff_ready = 1'b1;
    if_n.block_in_valid = 1'b1;
    @(negedge clk);
    if_n.block_in_valid = 1'b0;
    beat = 0; stall = 0; cyc = 0;
    while (beat < 64 && cyc < 200) begin
      if_n.coeff_ready = !(beat == 10 && stall < 3);
      checks++;
      if ({if_n.coeff_valid, if_n.coeff_index, if_n.coeff_out} !== {1'b1, 6'(beat), blk[beat]}) begin
        errors++;
        $display("FAIL bp_beat %0d cyc %0d: got vld=%b idx=%0d out=%h want 1/%0d/%h", beat, cyc,
                 if_n.coeff_valid, if_n.coeff_index, if_n.coeff_out, beat, blk[beat]);
      end
      if (if_n.coeff_ready) beat++;
      else stall++;
      cyc++;
      @(negedge clk);
    end
    if_n.coeff_ready = 1'b1;
    checks++;
    if (cyc !== 67) begin
      errors++;
      $display("FAIL bp_cycles: got %0d want 67", cyc);
    end
    checks++;
    if ({if_n.block_done, if_n.coeff_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_done: got done/vld=%b want 10", {if_n.block_done, if_n.coeff_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    if_n.block_in_flat = {64{16'h7FFF}};
    if_n.coeff_ready = 1'b1;
    if_n.block_in_valid = 1'b1;
    @(negedge clk);
    if_n.block_in_flat = {64{16'h8000}};  // B waits with valid held through A
    for (int b = 0; b < 64; b++) begin
      checks++;
      if ({if_n.coeff_valid, if_n.block_in_ready, if_n.coeff_out} !== {2'b10, 16'h7FFF}) begin
        errors++;
        $display("FAIL b2b_a_beat %0d: got vld=%b rdy=%b out=%h want 1/0/7fff", b,
                 if_n.coeff_valid, if_n.block_in_ready, if_n.coeff_out);
      end
      @(negedge clk);
    end
    checks++;
    if ({if_n.block_done, if_n.block_in_ready, if_n.coeff_valid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_a_done: got done/rdy/vld=%b want 110",
               {if_n.block_done, if_n.block_in_ready, if_n.coeff_valid});
    end
    @(negedge clk);
    if_n.block_in_valid = 1'b0;
    for (int b = 0; b < 64; b++) begin
      checks++;
      if ({if_n.coeff_valid, if_n.coeff_index, if_n.coeff_out} !== {1'b1, 6'(b), 16'h8000}) begin
        errors++;
        $display("FAIL b2b_b_beat %0d: got vld=%b idx=%0d out=%h want 1/%0d/8000", b,
                 if_n.coeff_valid, if_n.coeff_index, if_n.coeff_out, b);
      end
      @(negedge clk);
    end
    checks++;
    if (if_n.block_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b_done: got %b want 1", if_n.block_done);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 64; k++) blk[k] = W'(k) ^ 16'h5A00;
    if_z.block_in_flat = pack_blk();
    if_z.coeff_ready = 1'b1;
    if_z.block_in_valid = 1'b1;
    @(negedge clk);
    if_z.block_in_valid = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if ({if_z.coeff_valid, if_z.coeff_index} !== {1'b1, 6'(zz_ref[30])}) begin
      errors++;
      $display("FAIL mr_beat30: got vld=%b idx=%0d want 1/%0d", if_z.coeff_valid, if_z.coeff_index, zz_ref[30]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_z.coeff_valid, if_z.block_in_ready, if_z.block_done} !== 3'b010) begin
      errors++;
      $display("FAIL mr_async: got vld/rdy/done=%b want 010",
               {if_z.coeff_valid, if_z.block_in_ready, if_z.block_done});
    end
    checks++;
    if ({if_z.coeff_out, if_z.coeff_index} !== 22'd0) begin
      errors++;
      $display("FAIL mr_clear: got out=%h idx=%0d want 0/0", if_z.coeff_out, if_z.coeff_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({if_z.coeff_valid, if_z.block_done} !== 2'b00) begin
        errors++;
        $display("FAIL mr_quiet cyc %0d: got vld/done=%b want 00", c, {if_z.coeff_valid, if_z.block_done});
      end
    end
    for (int k = 0; k < 64; k++) blk[k] = W'(16'hF000 + k);
    if_z.block_in_flat = pack_blk();
    if_z.block_in_valid = 1'b1;
    @(negedge clk);
    if_z.block_in_valid = 1'b0;
    for (int b = 0; b < 64; b++) begin
      checks++;
      if ({if_z.coeff_valid, if_z.coeff_index, if_z.coeff_out} !==
          {1'b1, 6'(zz_ref[b]), blk[zz_ref[b]]}) begin
        errors++;
        $display("FAIL mr_fresh_beat %0d: got vld=%b idx=%0d out=%h want 1/%0d/%h", b,
                 if_z.coeff_valid, if_z.coeff_index, if_z.coeff_out, zz_ref[b], blk[zz_ref[b]]);
      end
      @(negedge clk);
    end
    checks++;
    if (if_z.block_done !== 1'b1) begin
      errors++;
      $display("FAIL mr_fresh_done: got %b want 1", if_z.block_done);
    end
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int got, cyc;
    bit done_seen;
    for (int k = 0; k < 64; k++) begin
      blk[k] = W'($urandom_range(0, 65535));
      rx[k]  = ~blk[k];
    end
    if_z.block_in_flat = pack_blk();
    if_z.coeff_ready = 1'b1;
    if_z.block_in_valid = 1'b1;
    @(negedge clk);
    if_z.block_in_valid = 1'b0;
    got = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      checks++;
      if (if_z.block_done && if_z.coeff_valid) begin
        errors++;
        $display("FAIL lb_overlap cyc %0d: done and valid both high", cyc);
      end
      if (if_z.block_done) done_seen = 1'b1;
      else begin
        if_z.coeff_ready = 1'($urandom_range(0, 1));
        if (if_z.coeff_valid && if_z.coeff_ready) begin
          rx[if_z.coeff_index] = if_z.coeff_out;
          got++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    if_z.coeff_ready = 1'b1;
    checks++;
    if (!done_seen || got !== 64) begin
      errors++;
      $display("FAIL lb_count: got beats=%0d done=%b want 64/1", got, done_seen);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (rx[k] !== blk[k]) begin
        errors++;
        $display("FAIL lb_coeff %0d: got %h want %h", k, rx[k], blk[k]);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_natural();
    test_zigzag();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coeff_serializer.md
# coeff_serializer

Converts one 8x8 block of quantized coefficients, presented as a 64-entry flat vector under a valid/ready handshake, into a stream of one coefficient per beat with its natural-order index, followed by a one-cycle `block_done` pulse. It is the transmit-side counterpart of the coefficient accumulator. It feeds a per-coefficient consumer such as the accumulator, a dequantizer, or a bench scoreboard. Scan order is natural or zigzag, selected by parameter.

## Interface
- `WIDTH`, default 16: coefficient width, signed two's complement.
- `ZIGZAG`, default 1: 1 = emit in JPEG zigzag scan order; 0 = emit in natural order 0..63.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `block_in_flat` input, WIDTH*64 bits: block; coefficient `k` (natural order, row-major) occupies bits `[k*WIDTH +: WIDTH]`.
- `block_in_valid` input, 1 bit: block is valid.
- `block_in_ready` output, 1 bit: serializer can capture a block this cycle.
- `coeff_out` output, WIDTH bits: current coefficient.
- `coeff_index` output, 6 bits: natural-order index of `coeff_out`.
- `coeff_valid` output, 1 bit: `coeff_out`/`coeff_index` are valid.
- `coeff_ready` input, 1 bit: downstream accepts the current coefficient.
- `block_done` output, 1 bit: one-cycle pulse after the 64th coefficient is accepted.

## Operation
- State machine states:
  - IDLE: `block_in_ready`=1, `coeff_valid`=0.
  - SEND: `block_in_ready`=0, `coeff_valid`=1.
  - DONE: `block_in_ready`=1, `coeff_valid`=0, `block_done`=1.
- Capture: `block_in_valid && block_in_ready` copies the whole vector into a 64xWIDTH internal buffer, clears scan position `pos` to 0, and goes to SEND.
- SEND, per beat:
  - `coeff_index` = `zz(pos)` when ZIGZAG=1, else `pos`.
  - `coeff_out` = `buf[coeff_index]`.
- Beat handshake: `coeff_valid && coeff_ready`.
  - On a beat, `pos` increments.
  - On the beat where `pos`=63, go to DONE instead of incrementing; `pos` does not wrap.
- Backpressure: while `coeff_valid && !coeff_ready`, `coeff_out` and `coeff_index` hold stable. `coeff_valid` never drops before its beat.
- DONE lasts exactly one cycle.
  - If `block_in_valid`=1 in DONE, capture the new block and go to SEND.
  - Otherwise go to IDLE.
- `block_in_flat` is sampled only at capture; it may change freely afterward.
- Coefficients pass through bit-exact: no sign extension, no saturation.
- Zigzag table is the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.

## Timing
- Reset values: state IDLE, `pos`=0, buffer all zero, `coeff_valid`=0, `block_done`=0, `coeff_out`=0, `coeff_index`=0.
- `block_in_ready`=1 as soon as `rst_n` is low and throughout IDLE.
- Latency:
  - Capture in cycle N gives the first `coeff_valid` in cycle N+1.
  - With `coeff_ready` held at 1, the last beat is in N+64 and `block_done` is in N+65.
  - Back-to-back blocks capture in the DONE cycle (N+65), so the next block's first beat is in N+66. Steady-state throughput is 65 cycles per block.
- `block_done` is never coincident with `coeff_valid`, so a consumer that latches its buffer on `block_done` sees all 64 writes.
- `block_in_ready` is a decode of the registered state only; it has no combinational path from `coeff_ready` or `block_in_valid`.
- Reset mid-block: the block is abandoned immediately. No further beats are emitted and no `block_done` is issued.
- `block_in_valid` asserted during SEND is ignored. The upstream holds it until ready.

## Structure
- Shared package (`jpeg_pkg`):
  - constants `BLOCK_COEFFS`=64 and `COEFF_W`=16;
  - the zigzag table as a function `zz(pos)`.
- One natural sub-module: `zigzag_rom`, a combinational 6-bit scan position to 6-bit natural index map built on `zz`. It is shared with the decoder's entropy stage.
- The state register, `pos` counter and buffer stay in this module.

## Test plan
- Natural order: ZIGZAG=0, block[k]=k+100, `coeff_ready`=1 -> beats in cycles N+1..N+64 with index k, value k+100; `block_done` in N+65 only.
- Zigzag: ZIGZAG=1, block[k]=k -> beat 2 shows index 8, value 8; beat 5 index 2; beat 63 index 63; 64 beats total.
- Backpressure: drop `coeff_ready` for 3 cycles at beat 10 -> index/value held for those 3 cycles; total 64 beats; `block_done` delayed by 3 cycles.
- Back-to-back: block A (all 0x7FFF), block B (all 0x8000) with `block_in_valid` held -> B captured in A's `block_done` cycle; B's first beat 1 cycle later, value 0x8000.
- Mid-block reset: assert `rst_n`=0 at beat 30 -> `coeff_valid`=0 and `block_in_ready`=1 immediately; no `block_done`. Afterward a fresh block serializes from index 0.
- Accumulator loopback: serializer feeding the accumulator with random signed values -> the accumulator's `block_out_flat` equals the input vector exactly.
